// File: rtl/router_port_ctrl.sv
// Purpose: per-packet port controller; latches destination, steers writes, watches reader stalls.
// Latency: write_enb/fifo_full/vld_out are combinational; soft_reset pulses are registered (1 cycle).
// Backpressure: the addressed FIFO's full flag goes back to the FSM; stalled readers get a flush pulse.
//
// Ports:
//   clock, resetn                 - single clock, synchronous active-low reset
//   detect_add, data_in[1:0]      - latch destination address (11 = no port)
//   write_enb_reg                 - FSM write strobe, steered to write_enb[2:0] (one-hot)
//   read_enb_0..2, empty_0..2     - reader pop strobes and FIFO empty flags
//   full_0..2 -> fifo_full        - full flag of the addressed FIFO
//   vld_out_0..2                  - port holds data (~empty)
//   soft_reset_0..2               - one-cycle flush pulse after TIMEOUT stalled cycles
module router_port_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [1:0]       addr_q;
    logic [2:0]       vld;
    logic [2:0]       stall;
    logic [2:0]       soft_reset_q;
    logic [CNT_W-1:0] cnt_q [3];

    // Valid is a pure function of the FIFO flags, deliberately outside reset.
    assign vld       = ~{empty_2, empty_1, empty_0};
    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    assign stall = vld & ~{read_enb_2, read_enb_1, read_enb_0};

    assign soft_reset_0 = soft_reset_q[0];
    assign soft_reset_1 = soft_reset_q[1];
    assign soft_reset_2 = soft_reset_q[2];

    // Destination latch; 11 is stored as-is and means "no port".
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q <= 2'b11;
        end else if (detect_add) begin
            addr_q <= data_in;
        end
    end

    // Steering reads the registered address, so a same-cycle detect_add
    // only takes effect on the following write.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    // Stall timers: count consecutive stalled cycles; on the TIMEOUT-th one
    // fire a single flush pulse and start over, so a persistent stall
    // produces a pulse every TIMEOUT cycles.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]        <= CNT_ZERO;
                soft_reset_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!stall[i]) begin
                    cnt_q[i]        <= CNT_ZERO;
                    soft_reset_q[i] <= 1'b0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]        <= CNT_ZERO;
                    soft_reset_q[i] <= 1'b1;
                end else begin
                    cnt_q[i]        <= cnt_q[i] + CNT_ONE;
                    soft_reset_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule
